// File: rtl/dmem_mmio.sv
// Data-memory responder: word-addressed RAM plus an MMIO window holding GPIO,
// a 64-bit cycle counter with hi-word snapshot, and a one-shot down-timer.
module dmem_mmio #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [23:0] MMIO_TAG = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  output logic [31:0] rdata,
  output logic [15:0] gpio_out,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CYC_W  = 64;

  localparam logic [7:0] OFF_GPIO   = 8'h00;
  localparam logic [7:0] OFF_CYC_LO = 8'h01;
  localparam logic [7:0] OFF_CYC_HI = 8'h02;
  localparam logic [7:0] OFF_TIMER  = 8'h03;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h05;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CYC_W-1:0]  cycle;
  logic [DATA_W-1:0] hi_shadow;
  logic [DATA_W-1:0] timer_cnt;
  logic              irq_pending;
  logic              irq_en;

  logic              sel_mmio;
  logic              sel_ram;
  logic [7:0]        off;
  logic [ADDR_W-1:0] ram_idx;
  logic              wr_mmio;
  logic              wr_gpio;
  logic              wr_timer;
  logic              wr_status;
  logic              wr_ctrl;
  logic              snap_hi;
  logic              timer_fire;

  // Address decode; MMIO takes priority over RAM.
  always_comb begin
    sel_mmio   = (addr[31:8] == MMIO_TAG);
    sel_ram    = !sel_mmio && (addr[31:ADDR_W] == '0);
    off        = addr[7:0];
    ram_idx    = addr[ADDR_W-1:0];
    wr_mmio    = memwrite && sel_mmio && !rst;
    wr_gpio    = wr_mmio && (off == OFF_GPIO);
    wr_timer   = wr_mmio && (off == OFF_TIMER);
    wr_status  = wr_mmio && (off == OFF_STATUS);
    wr_ctrl    = wr_mmio && (off == OFF_CTRL);
    snap_hi    = sel_mmio && (off == OFF_CYC_LO) && !memwrite;
    timer_fire = !wr_timer && (timer_cnt == DATA_W'(1));
  end

  // Combinational read path so the core can capture at the same edge.
  always_comb begin
    rdata = '0;
    if (sel_mmio) begin
      case (off)
        OFF_GPIO:   rdata = {16'h0000, gpio_out};
        OFF_CYC_LO: rdata = cycle[31:0];
        OFF_CYC_HI: rdata = hi_shadow;
        OFF_TIMER:  rdata = timer_cnt;
        OFF_STATUS: rdata = {31'h0, irq_pending};
        OFF_CTRL:   rdata = {31'h0, irq_en};
        default:    rdata = '0;
      endcase
    end else if (sel_ram) begin
      rdata = mem[ram_idx];
    end
  end

  assign irq = irq_pending && irq_en;

  // RAM contents survive reset; stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (memwrite && sel_ram && !rst) begin
      mem[ram_idx] <= wdata;
    end
  end

  // MMIO registers, cycle counter and timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out    <= '0;
      cycle       <= '0;
      hi_shadow   <= '0;
      timer_cnt   <= '0;
      irq_pending <= 1'b0;
      irq_en      <= 1'b0;
    end else begin
      cycle <= cycle + CYC_W'(1);
      if (snap_hi) begin
        hi_shadow <= cycle[63:32];
      end
      if (wr_gpio) begin
        gpio_out <= wdata[15:0];
      end
      if (wr_ctrl) begin
        irq_en <= wdata[0];
      end
      // A store always beats the decrement in the same cycle.
      if (wr_timer) begin
        timer_cnt <= wdata;
      end else if (timer_cnt != '0) begin
        timer_cnt <= timer_cnt - DATA_W'(1);
      end
      // Setting on expiry wins over a simultaneous W1C.
      if (timer_fire) begin
        irq_pending <= 1'b1;
      end else if (wr_status && wdata[0]) begin
        irq_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: behavioural model checked every cycle plus
// hand-computed expectations from the test plan.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memwrite;
  logic [31:0] rdata;
  logic [15:0] gpio_out;
  logic        irq;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .memwrite(memwrite),
    .rdata(rdata), .gpio_out(gpio_out), .irq(irq)
  );

  localparam logic [31:0] A_GPIO   = 32'hFFFF_FF00;
  localparam logic [31:0] A_CYC_LO = 32'hFFFF_FF01;
  localparam logic [31:0] A_CYC_HI = 32'hFFFF_FF02;
  localparam logic [31:0] A_TIMER  = 32'hFFFF_FF03;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_FF05;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per rising edge.
  logic [31:0] m_mem [1024];
  bit          m_valid [1024];
  logic [15:0] m_gpio;
  logic [63:0] m_cycle;
  logic [31:0] m_hs;
  logic [31:0] m_t;
  logic        m_p;
  logic        m_en;
  bit          m_init = 1'b0;

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFF;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return !is_mmio(a) && (a < 32'd1024);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (is_mmio(a)) begin
      case (a[7:0])
        8'h00:   return {16'h0, m_gpio};
        8'h01:   return m_cycle[31:0];
        8'h02:   return m_hs;
        8'h03:   return m_t;
        8'h04:   return {31'h0, m_p};
        8'h05:   return {31'h0, m_en};
        default: return 32'h0;
      endcase
    end
    if (is_ram(a)) return m_mem[a[9:0]];
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    bit mm;
    bit fire;
    logic [7:0] o;
    if (rst) begin
      m_gpio = '0; m_cycle = '0; m_hs = '0; m_t = '0; m_p = 1'b0; m_en = 1'b0;
      m_init = 1'b1;
    end else begin
      mm = is_mmio(addr);
      o = addr[7:0];
      fire = 1'b0;
      if (mm && o == 8'h01 && !memwrite) m_hs = m_cycle[63:32];
      if (memwrite && mm && o == 8'h00) m_gpio = wdata[15:0];
      if (memwrite && mm && o == 8'h05) m_en = wdata[0];
      if (memwrite && mm && o == 8'h03) m_t = wdata;
      else if (m_t != 0) begin
        m_t = m_t - 1;
        fire = (m_t == 0);
      end
      if (fire) m_p = 1'b1;
      else if (memwrite && mm && o == 8'h04 && wdata[0]) m_p = 1'b0;
      if (memwrite && is_ram(addr)) begin
        m_mem[addr[9:0]] = wdata;
        m_valid[addr[9:0]] = 1'b1;
      end
      m_cycle = m_cycle + 1;
    end
  end

  // Per-cycle comparison on the falling edge; never-written RAM is skipped.
  always @(negedge clk) begin
    if (m_init) begin
      if (!is_ram(addr) || m_valid[addr[9:0]]) check("rdata", rdata, exp_rd(addr));
      check("gpio_out", 32'(gpio_out), 32'(m_gpio));
      check("irq", 32'(irq), 32'(m_p && m_en));
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we);
    addr = a; wdata = d; memwrite = we;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; memwrite = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; memwrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    idle(2);
    rst = 1'b0;
    rd("rst_gpio_reg", A_GPIO, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // RAM and decode
    op(32'd5, 32'hDEAD_BEEF, 1'b1);
    rd("ram5", 32'd5, 32'hDEAD_BEEF);
    op(32'd6, 32'h0000_0001, 1'b1);
    op(32'd6, 32'h0000_0002, 1'b1);
    rd("ram6_overwrite", 32'd6, 32'h0000_0002);
    op(32'd1024, 32'hCAFE_F00D, 1'b1);
    rd("ram_oob", 32'd1024, 32'h0);
    op(A_GPIO, 32'h0001_A5A5, 1'b1);
    check("gpio_out", 32'(gpio_out), 32'h0000_A5A5);
    rd("gpio_rd", A_GPIO, 32'h0000_A5A5);
    rd("mmio_hole", 32'hFFFF_FF07, 32'h0);
    rd("unmapped", 32'h8000_0000, 32'h0);

    // Timer: store 3, interrupt in the fourth cycle after the store edge
    op(A_CTRL, 32'hFFFF_FFFF, 1'b1);
    rd("ctrl_rd", A_CTRL, 32'h1);
    op(A_TIMER, 32'd3, 1'b1);
    rd("timer_k", A_TIMER, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      check("irq_early", 32'(irq), 32'h0);
      idle(1);
    end
    check("irq_rise", 32'(irq), 32'h1);
    rd("status_set", A_STATUS, 32'h1);
    op(A_STATUS, 32'h0000_0000, 1'b1);
    check("w0c_noeffect", 32'(irq), 32'h1);
    op(A_STATUS, 32'h0000_0001, 1'b1);
    check("w1c_irq", 32'(irq), 32'h0);
    op(A_TIMER, 32'd0, 1'b1);
    idle(3);
    check("timer_zero_noirq", 32'(irq), 32'h0);

    // Collision: expiry and W1C on the same edge
    op(A_TIMER, 32'd1, 1'b1);
    idle(1);
    check("pending_pre", 32'(irq), 32'h1);
    op(A_TIMER, 32'd1, 1'b1);
    op(A_STATUS, 32'h1, 1'b1);
    check("collide_irq", 32'(irq), 32'h1);
    rd("collide_status", A_STATUS, 32'h1);
    op(A_STATUS, 32'h1, 1'b1);
    check("collide_clear", 32'(irq), 32'h0);
    op(A_TIMER, 32'd5, 1'b1);
    idle(1);
    op(A_TIMER, 32'd10, 1'b1);
    rd("timer_store_wins", A_TIMER, 32'd10);

    // Reset mid-countdown with a RAM store in the reset cycle
    op(A_GPIO, 32'h0000_1234, 1'b1);
    op(32'd7, 32'h1111_1111, 1'b1);
    op(A_TIMER, 32'd4, 1'b1);
    idle(1);
    rst = 1'b1; addr = 32'd7; wdata = 32'h2222_2222; memwrite = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; memwrite = 1'b0;
    rd("cycle_after_rst", A_CYC_LO, 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_irq2", 32'(irq), 32'h0);
    rd("rst_timer", A_TIMER, 32'h0);
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_hi", A_CYC_HI, 32'h0);
    rd("ram7_kept", 32'd7, 32'h1111_1111);
    rd("ram5_kept", 32'd5, 32'hDEAD_BEEF);
    op(A_CTRL, 32'h1, 1'b1);
    idle(6);
    check("no_irq_after_rst", 32'(irq), 32'h0);

    // Cycle snapshot across the low-word wrap
    addr = A_CYC_LO; memwrite = 1'b0;
    force dut.cycle = 64'h0000_0000_FFFF_FFFF;
    m_cycle = 64'h0000_0000_FFFF_FFFF;
    #1;
    check("cyc_lo_wrap", rdata, 32'hFFFF_FFFF);
    release dut.cycle;
    @(posedge clk); #1;
    rd("cyc_hi_snap", A_CYC_HI, 32'h0);
    rd("cyc_lo_after", A_CYC_LO, 32'h0);
    idle(1);
    rd("cyc_hi_next", A_CYC_HI, 32'h1);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
